// File: rtl/uart_cmd_dispatch.sv
// ASCII command parser: "$<id>[,<arg>...]\r\n" decimal fields onto a valid/ready command port.
// Optional echo of accepted RX bytes to a 2-entry TX FIFO when UART_CMD_ECHO_EN is defined.
module uart_cmd_dispatch #(
    parameter int unsigned FIELD_W  = 8,
    parameter int unsigned NUM_ARGS = 2
) (
    input  logic                            clk,
    input  logic                            arst_n,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic                            cmd_valid,
    input  logic                            cmd_ready,
    output logic [FIELD_W-1:0]              cmd_id,
    output logic [NUM_ARGS*FIELD_W-1:0]     cmd_args,
    output logic [$clog2(NUM_ARGS+1)-1:0]   cmd_nargs,
    output logic                            err_valid,
    output logic [2:0]                      err_code,
    output logic [7:0]                      tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready
);

    localparam int unsigned ACC_W = FIELD_W + 4;
    localparam int unsigned IDX_W = $clog2(NUM_ARGS + 1);

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_SP     = 8'h20;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_0      = 8'h30;
    localparam logic [7:0] CH_9      = 8'h39;

    localparam logic [2:0] ERR_CHAR  = 3'd1;
    localparam logic [2:0] ERR_OVF   = 3'd2;
    localparam logic [2:0] ERR_NARGS = 3'd3;
    localparam logic [2:0] ERR_NOLF  = 3'd4;
    localparam logic [2:0] ERR_BUSY  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_FIELD, S_CR, S_HOLD} state_e;

    state_e                          state_q, state_d;
    logic [ACC_W-1:0]                acc_q, acc_d, acc_dig;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [IDX_W-1:0]                nargs_q, nargs_d;
    logic [NUM_ARGS:0][FIELD_W-1:0]  fields_q, fields_d;
    logic                            cmd_valid_q, cmd_valid_d;
    logic                            err_valid_q, err_valid_d;
    logic [2:0]                      err_code_q, err_code_d;
    logic                            is_digit, restart, store;

    // Digits '0'..'9' carry their value in the low nibble; acc*10 = acc*8 + acc*2.
    assign is_digit = (rx_data >= CH_0) && (rx_data <= CH_9);
    assign acc_dig  = (acc_q << 3) + (acc_q << 1) + ACC_W'(rx_data[3:0]);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        nargs_d     = nargs_q;
        fields_d    = fields_q;
        cmd_valid_d = cmd_valid_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        restart     = 1'b0;
        store       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == CH_DOLLAR) restart = 1'b1;
            end
            S_FIELD: begin
                if (rx_valid) begin
                    if (rx_data == CH_DOLLAR) begin
                        restart = 1'b1;
                    end else if (is_digit) begin
                        if (acc_dig[ACC_W-1:FIELD_W] != '0) begin
                            err_valid_d = 1'b1;
                            err_code_d  = ERR_OVF;
                            state_d     = S_IDLE;
                        end else begin
                            acc_d = acc_dig;
                        end
                    end else if (rx_data == CH_COMMA) begin
                        if (idx_q == IDX_W'(NUM_ARGS)) begin
                            err_valid_d = 1'b1;
                            err_code_d  = ERR_NARGS;
                            state_d     = S_IDLE;
                        end else begin
                            store = 1'b1;
                            idx_d = idx_q + IDX_W'(1);
                            acc_d = '0;
                        end
                    end else if (rx_data == CH_CR) begin
                        store   = 1'b1;
                        nargs_d = idx_q;
                        state_d = S_CR;
                    end else if (rx_data != CH_SP) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_CHAR;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_CR: begin
                if (rx_valid) begin
                    if (rx_data == CH_LF) begin
                        state_d     = S_HOLD;
                        cmd_valid_d = 1'b1;
                    end else if (rx_data == CH_DOLLAR) begin
                        restart = 1'b1;
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_NOLF;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                // Bytes arriving while a command is held are lost, even on the handshake cycle.
                if (rx_valid) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_BUSY;
                end
                if (cmd_ready) begin
                    state_d     = S_IDLE;
                    cmd_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (restart) begin
            state_d  = S_FIELD;
            acc_d    = '0;
            idx_d    = '0;
            nargs_d  = '0;
            fields_d = '0;
        end

        for (int unsigned k = 0; k <= NUM_ARGS; k++) begin
            if (store && idx_q == IDX_W'(k)) fields_d[k] = acc_q[FIELD_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            nargs_q     <= '0;
            fields_q    <= '0;
            cmd_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            nargs_q     <= nargs_d;
            fields_q    <= fields_d;
            cmd_valid_q <= cmd_valid_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_id    = fields_q[0];
    assign cmd_args  = fields_q[NUM_ARGS:1];
    assign cmd_nargs = nargs_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;

`ifdef UART_CMD_ECHO_EN
    // Two-entry shift FIFO: e0 is always the head so tx_data comes straight from a register.
    logic [1:0] ecnt_q, ecnt_d;
    logic [7:0] e0_q, e0_d, e1_q, e1_d;
    logic       tx_valid_q, tx_valid_d;
    logic       e_pop, e_push;

    always_comb begin
        e_pop  = (ecnt_q != 2'd0) && tx_ready;
        e_push = rx_valid && (state_q != S_HOLD) && (ecnt_q != 2'd2);
        ecnt_d = ecnt_q;
        e0_d   = e0_q;
        e1_d   = e1_q;
        if (e_pop) begin
            e0_d   = e1_q;
            ecnt_d = ecnt_q - 2'd1;
        end
        if (e_push) begin
            if (ecnt_d == 2'd0) e0_d = rx_data;
            else                e1_d = rx_data;
            ecnt_d = ecnt_d + 2'd1;
        end
        tx_valid_d = (ecnt_d != 2'd0);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ecnt_q     <= '0;
            e0_q       <= '0;
            e1_q       <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            ecnt_q     <= ecnt_d;
            e0_q       <= e0_d;
            e1_q       <= e1_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign tx_data  = e0_q;
    assign tx_valid = tx_valid_q;
`else
    logic unused_tx_ready;
    assign unused_tx_ready = tx_ready;
    assign tx_data         = '0;
    assign tx_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// Testbench for uart_cmd_dispatch: byte-level stimulus checked against a string-parsing
// reference model built from queues and integer arithmetic.
module tb_uart_cmd_dispatch;

    localparam int unsigned FW = 8;
    localparam int unsigned NA = 2;
    localparam int unsigned NW = $clog2(NA + 1);
    localparam int unsigned VW = FW + NA * FW + NW;

    logic             clk = 1'b0;
    logic             arst_n;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [FW-1:0]    cmd_id;
    logic [NA*FW-1:0] cmd_args;
    logic [NW-1:0]    cmd_nargs;
    logic             err_valid;
    logic [2:0]       err_code;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;

    uart_cmd_dispatch #(.FIELD_W(FW), .NUM_ARGS(NA)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_id    (cmd_id),
        .cmd_args  (cmd_args),
        .cmd_nargs (cmd_nargs),
        .err_valid (err_valid),
        .err_code  (err_code),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: command text in progress, completed fields, held result.
    bit m_active, m_after_cr, m_hold;
    int m_acc;
    int m_fields[$];
    int m_last_code;
    int e_id, e_nargs;
    int e_args[NA];

    function automatic void model_reset();
        m_active = 0; m_after_cr = 0; m_hold = 0; m_acc = 0; m_last_code = 0;
        m_fields.delete();
        e_id = 0; e_nargs = 0;
        for (int k = 0; k < NA; k++) e_args[k] = 0;
    endfunction

    function automatic void model_start();
        m_active = 1; m_after_cr = 0; m_acc = 0;
        m_fields.delete();
    endfunction

    function automatic int model_byte(input logic [7:0] b);
        int err = 0;
        if (m_hold) begin
            err = 5;
        end else if (m_after_cr) begin
            if (b == 8'h0A) begin
                m_after_cr = 0;
                m_hold     = 1;
                e_id       = m_fields[0];
                e_nargs    = m_fields.size() - 1;
                for (int k = 0; k < NA; k++) e_args[k] = (k + 1 < m_fields.size()) ? m_fields[k+1] : 0;
            end else if (b == "$") begin
                model_start();
            end else begin
                err = 4; m_after_cr = 0;
            end
        end else if (m_active) begin
            if (b == "$") begin
                model_start();
            end else if (b >= "0" && b <= "9") begin
                m_acc = m_acc * 10 + (int'(b) - 48);
                if (m_acc > (1 << FW) - 1) begin err = 2; m_active = 0; end
            end else if (b == " ") begin
                err = 0;
            end else if (b == ",") begin
                m_fields.push_back(m_acc);
                m_acc = 0;
                if (m_fields.size() > NA) begin err = 3; m_active = 0; end
            end else if (b == 8'h0D) begin
                m_fields.push_back(m_acc);
                m_active = 0; m_after_cr = 1;
            end else begin
                err = 1; m_active = 0;
            end
        end else if (b == "$") begin
            model_start();
        end
        if (err != 0) m_last_code = err;
        return err;
    endfunction

    function automatic logic [VW-1:0] exp_cmd();
        return {FW'(e_id), FW'(e_args[1]), FW'(e_args[0]), NW'(e_nargs)};
    endfunction

    // Drives one byte for a single cycle; a held command with ready high completes first.
    task automatic drive_byte(input logic [7:0] b, output int exp_err);
        if (m_hold && cmd_ready) m_hold = 0;
        exp_err = model_byte(b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cmd_valid, err_valid, err_code, cmd_id, cmd_args, cmd_nargs} !== '0) begin
            n_fail++;
            $display("FAIL reset_cmd: valid=%0b err=%0b code=%0d id=%0d args=%h nargs=%0d, want all 0",
                     cmd_valid, err_valid, err_code, cmd_id, cmd_args, cmd_nargs);
        end
        n_checks++;
        if ({tx_valid, tx_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_tx: tx_valid=%0b tx_data=%h, want 0", tx_valid, tx_data);
        end
        model_reset();
        arst_n = 1'b1;
    endtask

    task automatic test_basic();
        string cmds[3] = '{"$2,1,1\r\n", "$2 \r\n", "$3,10,5\r\n"};
        int e;
        cmd_ready = 1'b1;
        foreach (cmds[i]) begin
            for (int j = 0; j < cmds[i].len(); j++) begin
                drive_byte(cmds[i][j], e);
                n_checks++;
                if (err_valid !== (e != 0) || err_code !== 3'(m_last_code)) begin
                    n_fail++;
                    $display("FAIL basic_err cmd%0d byte%0d: err_valid=%0b code=%0d, want %0b/%0d",
                             i, j, err_valid, err_code, e != 0, m_last_code);
                end
                n_checks++;
                if (cmd_valid !== m_hold || (m_hold && {cmd_id, cmd_args, cmd_nargs} !== exp_cmd())) begin
                    n_fail++;
                    $display("FAIL basic_cmd cmd%0d byte%0d: valid=%0b vec=%h, want %0b/%h",
                             i, j, cmd_valid, {cmd_id, cmd_args, cmd_nargs}, m_hold, exp_cmd());
                end
            end
            @(negedge clk);
            m_hold = 0;
            n_checks++;
            if (cmd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_drop cmd%0d: cmd_valid=%0b after handshake, want 0", i, cmd_valid);
            end
        end
    endtask

    task automatic test_errors();
        string cmds[5] = '{"$1,300\r\n", "$4,23,73\r\n", "$1,2,3,4\r\n", "$1x\r\n", "$1\rZ"};
        int e;
        cmd_ready = 1'b1;
        foreach (cmds[i]) begin
            for (int j = 0; j < cmds[i].len(); j++) begin
                drive_byte(cmds[i][j], e);
                n_checks++;
                if (err_valid !== (e != 0) || err_code !== 3'(m_last_code)) begin
                    n_fail++;
                    $display("FAIL errors_err cmd%0d byte%0d: err_valid=%0b code=%0d, want %0b/%0d",
                             i, j, err_valid, err_code, e != 0, m_last_code);
                end
                n_checks++;
                if (cmd_valid !== m_hold || (m_hold && {cmd_id, cmd_args, cmd_nargs} !== exp_cmd())) begin
                    n_fail++;
                    $display("FAIL errors_cmd cmd%0d byte%0d: valid=%0b vec=%h, want %0b/%h",
                             i, j, cmd_valid, {cmd_id, cmd_args, cmd_nargs}, m_hold, exp_cmd());
                end
            end
        end
    endtask

    task automatic test_busy();
        string s = "$2,1,0\r\n$5\r\n$6\r\n";
        int e;
        int busy_errs = 0;
        cmd_ready = 1'b0;
        for (int j = 0; j < s.len(); j++) begin
            if (j == 12) begin
                cmd_ready = 1'b1;
                @(negedge clk);
                n_checks++;
                if (cmd_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_release: cmd_valid=%0b one cycle after ready, want 0", cmd_valid);
                end
            end
            drive_byte(s[j], e);
            if (e == 5) busy_errs++;
            n_checks++;
            if (err_valid !== (e != 0) || err_code !== 3'(m_last_code)) begin
                n_fail++;
                $display("FAIL busy_err byte%0d: err_valid=%0b code=%0d, want %0b/%0d",
                         j, err_valid, err_code, e != 0, m_last_code);
            end
            n_checks++;
            if (cmd_valid !== m_hold || (m_hold && {cmd_id, cmd_args, cmd_nargs} !== exp_cmd())) begin
                n_fail++;
                $display("FAIL busy_cmd byte%0d: valid=%0b vec=%h, want %0b/%h",
                         j, cmd_valid, {cmd_id, cmd_args, cmd_nargs}, m_hold, exp_cmd());
            end
            if (j < 12 && cmd_valid === 1'b1) begin
                n_checks++;
                if (cmd_id !== FW'(2)) begin
                    n_fail++;
                    $display("FAIL busy_hold byte%0d: cmd_id=%0d, want 2", j, cmd_id);
                end
            end
        end
        n_checks++;
        if (busy_errs != 4) begin
            n_fail++;
            $display("FAIL busy_count: model saw %0d dropped bytes, want 4", busy_errs);
        end
    endtask

    task automatic test_resync();
        string s = "$7,1$3,4\r\n";
        int e;
        cmd_ready = 1'b1;
        for (int j = 0; j < s.len(); j++) begin
            drive_byte(s[j], e);
            n_checks++;
            if (err_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL resync_err byte%0d: err_valid=%0b code=%0d, want 0", j, err_valid, err_code);
            end
        end
        n_checks++;
        if (cmd_valid !== 1'b1 || {cmd_id, cmd_args, cmd_nargs} !== {8'd3, 8'd0, 8'd4, 2'd1}) begin
            n_fail++;
            $display("FAIL resync_cmd: valid=%0b id=%0d args=%h nargs=%0d, want 1/3/0004/1",
                     cmd_valid, cmd_id, cmd_args, cmd_nargs);
        end
    endtask

    task automatic test_simultaneous();
        string s = "$8\r\n";
        int e;
        cmd_ready = 1'b1;
        @(negedge clk);
        m_hold = 0;
        cmd_ready = 1'b0;
        for (int j = 0; j < s.len(); j++) drive_byte(s[j], e);
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_id !== FW'(8)) begin
            n_fail++;
            $display("FAIL simul_hold: valid=%0b id=%0d, want 1/8", cmd_valid, cmd_id);
        end
        e = model_byte("A");
        @(negedge clk);
        rx_data = "A"; rx_valid = 1'b1; cmd_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        m_hold = 0;
        n_checks++;
        if (err_valid !== 1'b1 || err_code !== 3'(e) || cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_drop: err=%0b code=%0d valid=%0b, want 1/%0d/0", err_valid, err_code, cmd_valid, e);
        end
    endtask

    task automatic test_random();
        string s;
        string term[5] = '{"\r\n", "\r\n", "x\r\n", "\rQ", "\r\n"};
        int e;
        cmd_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            s = ($urandom_range(0, 4) == 0) ? "A" : "";
            s = {s, $sformatf("$%0d", $urandom_range(0, 280))};
            for (int a = $urandom_range(0, 3); a > 0; a--) begin
                s = {s, ",", ($urandom_range(0, 5) == 0) ? "" : $sformatf("%0d", $urandom_range(0, 270))};
                if ($urandom_range(0, 5) == 0) s = {s, " "};
            end
            s = {s, term[$urandom_range(0, 4)]};
            for (int j = 0; j < s.len(); j++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                drive_byte(s[j], e);
                n_checks++;
                if (err_valid !== (e != 0) || err_code !== 3'(m_last_code)) begin
                    n_fail++;
                    $display("FAIL random_err \"%s\" byte%0d: err_valid=%0b code=%0d, want %0b/%0d",
                             s, j, err_valid, err_code, e != 0, m_last_code);
                end
                n_checks++;
                if (cmd_valid !== m_hold || (m_hold && {cmd_id, cmd_args, cmd_nargs} !== exp_cmd())) begin
                    n_fail++;
                    $display("FAIL random_cmd \"%s\" byte%0d: valid=%0b vec=%h, want %0b/%h",
                             s, j, cmd_valid, {cmd_id, cmd_args, cmd_nargs}, m_hold, exp_cmd());
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        string s = "$12,3";
        int e;
        cmd_ready = 1'b1;
        for (int j = 0; j < s.len(); j++) drive_byte(s[j], e);
        #3 arst_n = 1'b0;
        #1;
        n_checks++;
        if ({cmd_valid, err_valid, err_code, cmd_id, cmd_args, cmd_nargs, tx_valid, tx_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%0b err=%0b code=%0d id=%0d args=%h nargs=%0d tx=%0b/%h, want all 0",
                     cmd_valid, err_valid, err_code, cmd_id, cmd_args, cmd_nargs, tx_valid, tx_data);
        end
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;
        s = "4\r\n$9\r\n";
        for (int j = 0; j < s.len(); j++) drive_byte(s[j], e);
        n_checks++;
        if (cmd_valid !== 1'b1 || {cmd_id, cmd_args, cmd_nargs} !== {8'd9, 16'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_recover: valid=%0b id=%0d args=%h nargs=%0d, want 1/9/0/0",
                     cmd_valid, cmd_id, cmd_args, cmd_nargs);
        end
    endtask

    task automatic test_echo();
        string s = "$1,2";
        int e;
        @(negedge clk);
        m_hold = 0;
        tx_ready = 1'b0;
        for (int j = 0; j < s.len(); j++) drive_byte(s[j], e);
`ifdef UART_CMD_ECHO_EN
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== "$") begin
            n_fail++;
            $display("FAIL echo_head: tx_valid=%0b tx_data=%h, want 1/24", tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== "1") begin
            n_fail++;
            $display("FAIL echo_second: tx_valid=%0b tx_data=%h, want 1/31", tx_valid, tx_data);
        end
        @(negedge clk);
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL echo_drop: tx_valid=%0b after two pops, want 0", tx_valid);
        end
`else
        tx_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL echo_off: tx_valid=%0b tx_data=%h, want 0/00", tx_valid, tx_data);
        end
`endif
    endtask

    initial begin
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        cmd_ready = 1'b1;
        tx_ready  = 1'b1;
        model_reset();
        test_reset();
        test_basic();
        test_errors();
        test_busy();
        test_resync();
        test_simultaneous();
        test_random();
        test_reset_mid();
        test_echo();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
